// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage between decode and execute.
// Drives the register set read ports and bypasses same-cycle writeback data.
// Tracks pending writes in a scoreboard and stalls issue on RAW/WAW hazards.
// Operands are captured into a single output register for execute.
module operand_fetch #(
  parameter int unsigned RegisterCount = 32,
  parameter int unsigned RegBits       = $clog2(RegisterCount),
  parameter int unsigned Width         = 32
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [RegBits-1:0]       in_rs1,
  input  logic [RegBits-1:0]       in_rs2,
  input  logic [RegBits-1:0]       in_rd,
  input  logic                     in_rd_write,
  output logic [RegBits-1:0]       rf_q0_reg,
  output logic [RegBits-1:0]       rf_q1_reg,
  input  logic [Width-1:0]         rf_q0,
  input  logic [Width-1:0]         rf_q1,
  input  logic                     wb_valid,
  input  logic [RegBits-1:0]       wb_reg,
  input  logic [Width-1:0]         wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Width-1:0]         out_op1,
  output logic [Width-1:0]         out_op2,
  output logic [RegBits-1:0]       out_rd,
  output logic                     out_rd_write,
  output logic [RegisterCount-1:0] busy
);

  logic [RegisterCount-1:0] clr;
  logic [RegisterCount-1:0] eb;
  logic [RegisterCount-1:0] busy_next;
  logic                     hazard;
  logic                     accept;
  logic [Width-1:0]         op1;
  logic [Width-1:0]         op2;

  // Register 0 reads as zero; a same-cycle writeback wins over the stale register set value.
  function automatic logic [Width-1:0] select_operand(
    input logic [RegBits-1:0] rs,
    input logic [Width-1:0]   q,
    input logic               wv,
    input logic [RegBits-1:0] wr,
    input logic [Width-1:0]   wd
  );
    if (rs == '0)
      return '0;
    else if (wv && (wr == rs))
      return wd;
    else
      return q;
  endfunction

  assign rf_q0_reg = in_rs1;
  assign rf_q1_reg = in_rs2;

  // Writeback clears its pending bit in the same cycle so a waiting instruction can issue with the bypass.
  always_comb begin
    clr = '0;
    for (int unsigned r = 1; r < RegisterCount; r++) begin
      clr[r] = wb_valid && (wb_reg == RegBits'(r));
    end
  end

  assign eb = busy & ~clr;

  // Hazard detection and handshake; register 0 is never busy so it never stalls.
  always_comb begin
    hazard   = eb[in_rs1] || eb[in_rs2] || (in_rd_write && eb[in_rd]);
    in_ready = !res && !hazard && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    op1      = select_operand(in_rs1, rf_q0, wb_valid, wb_reg, wb_data);
    op2      = select_operand(in_rs2, rf_q1, wb_valid, wb_reg, wb_data);
  end

  // Next scoreboard: apply clears first so a same-cycle set of the same register wins.
  always_comb begin
    busy_next = eb;
    if (accept && in_rd_write && (in_rd != '0))
      busy_next[in_rd] = 1'b1;
  end

  // Output register and scoreboard state.
  always_ff @(posedge clk) begin
    if (res) begin
      busy         <= '0;
      out_valid    <= 1'b0;
      out_op1      <= '0;
      out_op2      <= '0;
      out_rd       <= '0;
      out_rd_write <= 1'b0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        out_valid    <= 1'b1;
        out_op1      <= op1;
        out_op2      <= op2;
        out_rd       <= in_rd;
        out_rd_write <= in_rd_write;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors with hand-computed expectations for operand_fetch.
module tb_operand_fetch;

  logic        clk;
  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic        in_rd_write;
  logic [4:0]  rf_q0_reg;
  logic [4:0]  rf_q1_reg;
  logic [31:0] rf_q0;
  logic [31:0] rf_q1;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_write;
  logic [31:0] busy;

  logic [31:0] regs [32];
  int unsigned total;
  int unsigned bad;

  operand_fetch #(
    .RegisterCount(32),
    .Width(32)
  ) dut (
    .clk(clk),
    .res(res),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_rd(in_rd),
    .in_rd_write(in_rd_write),
    .rf_q0_reg(rf_q0_reg),
    .rf_q1_reg(rf_q1_reg),
    .rf_q0(rf_q0),
    .rf_q1(rf_q1),
    .wb_valid(wb_valid),
    .wb_reg(wb_reg),
    .wb_data(wb_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op1(out_op1),
    .out_op2(out_op2),
    .out_rd(out_rd),
    .out_rd_write(out_rd_write),
    .busy(busy)
  );

  // Register set model: combinational read ports.
  assign rf_q0 = regs[rf_q0_reg];
  assign rf_q1 = regs[rf_q1_reg];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_rd_write = wr;
  endtask

  task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_valid = v;
    wb_reg   = r;
    wb_data  = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0100_0000 + i;
    regs[0] = 32'hFFFF_FFFF;
    regs[5] = 32'h0000_1234;
    regs[6] = 32'h0000_0010;
    res = 1'b1;
    out_ready = 1'b1;
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    wb(1'b0, 5'd0, 32'h0);

    // Reset with in_valid high
    #2;
    for (int c = 0; c < 2; c++) begin
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    #1;
    chk("rst_in_ready_last", {31'b0, in_ready}, 32'd0);
    step();
    res = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_rst_busy", busy, 32'd0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic issue
    issue(5'd5, 5'd6, 5'd7, 1'b1);
    #1;
    chk("rf_q0_reg", {27'b0, rf_q0_reg}, 32'd5);
    chk("rf_q1_reg", {27'b0, rf_q1_reg}, 32'd6);
    step();
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_op1", out_op1, 32'h0000_1234);
    chk("basic_op2", out_op2, 32'h0000_0010);
    chk("basic_rd", {27'b0, out_rd}, 32'd7);
    chk("basic_rdw", {31'b0, out_rd_write}, 32'd1);
    chk("basic_busy", busy, 32'h0000_0080);

    // RAW stall, then bypass on writeback
    issue(5'd7, 5'd6, 5'd8, 1'b1);
    #1;
    chk("raw_stall", {31'b0, in_ready}, 32'd0);
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_hold_op1", out_op1, 32'h0000_1234);
    chk("raw_busy_hold", busy, 32'h0000_0080);
    wb(1'b1, 5'd7, 32'hCAFE_BABE);
    #1;
    chk("raw_release", {31'b0, in_ready}, 32'd1);
    step();
    regs[7] = 32'hCAFE_BABE;
    wb(1'b0, 5'd0, 32'h0);
    chk("bypass_op1", out_op1, 32'hCAFE_BABE);
    chk("bypass_op2", out_op2, 32'h0000_0010);
    chk("bypass_rd", {27'b0, out_rd}, 32'd8);
    chk("bypass_busy", busy, 32'h0000_0100);

    // Register 0 sources and destination, writeback to register 0
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    wb(1'b1, 5'd0, 32'h0000_0055);
    #1;
    chk("r0_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("r0_op1", out_op1, 32'd0);
    chk("r0_op2", out_op2, 32'd0);
    chk("r0_busy", busy, 32'h0000_0100);

    // Bypass on rs2 while clearing x8; no destination write
    issue(5'd5, 5'd8, 5'd0, 1'b0);
    wb(1'b1, 5'd8, 32'h0000_0088);
    #1;
    chk("rs2_bypass_ready", {31'b0, in_ready}, 32'd1);
    step();
    regs[8] = 32'h0000_0088;
    wb(1'b0, 5'd0, 32'h0);
    chk("rs2_bypass_op1", out_op1, 32'h0000_1234);
    chk("rs2_bypass_op2", out_op2, 32'h0000_0088);
    chk("rs2_bypass_rdw", {31'b0, out_rd_write}, 32'd0);
    chk("rs2_bypass_busy", busy, 32'd0);

    // Backpressure
    issue(5'd5, 5'd6, 5'd10, 1'b1);
    step();
    chk("bp_first_op1", out_op1, 32'h0000_1234);
    chk("bp_first_busy", busy, 32'h0000_0400);
    out_ready = 1'b0;
    issue(5'd6, 5'd5, 5'd11, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      step();
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_op1", out_op1, 32'h0000_1234);
      chk("bp_rd", {27'b0, out_rd}, 32'd10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("bp_next_op1", out_op1, 32'h0000_0010);
    chk("bp_next_op2", out_op2, 32'h0000_1234);
    chk("bp_next_rd", {27'b0, out_rd}, 32'd11);
    chk("bp_next_busy", busy, 32'h0000_0C00);

    // Simultaneous set and clear of x9, with a WAW stall first
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    step();
    chk("sc_busy_set", busy, 32'h0000_0E00);
    #1;
    chk("waw_stall", {31'b0, in_ready}, 32'd0);
    wb(1'b1, 5'd9, 32'h0000_0099);
    #1;
    chk("waw_release", {31'b0, in_ready}, 32'd1);
    step();
    regs[9] = 32'h0000_0099;
    wb(1'b0, 5'd0, 32'h0);
    in_valid = 1'b0;
    chk("sc_busy_kept", busy, 32'h0000_0E00);
    chk("sc_valid", {31'b0, out_valid}, 32'd1);

    // Reset drops an in-flight output and ignores writeback
    out_ready = 1'b0;
    res = 1'b1;
    wb(1'b1, 5'd10, 32'h0000_00AA);
    step();
    res = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    chk("rst2_valid", {31'b0, out_valid}, 32'd0);
    chk("rst2_busy", busy, 32'd0);
    chk("rst2_op1", out_op1, 32'd0);
    chk("rst2_rd", {27'b0, out_rd}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read side of the register set: sends rs1/rs2 numbers to the register set's two combinational read ports and captures the returned operands into a skid-free output register for execute.
- Keeps a scoreboard of registers with writes still pending, and stalls issue on RAW and WAW hazards.
- Bypasses same-cycle writeback data, because the register set commits writes only at the clock edge.
- Sits between decode and execute; writeback drives the register set write port and, in parallel, this block's wb_* inputs.

Parameters:
- RegisterCount, 32 (`REGISTER_COUNT): number of architectural registers; register 0 is hardwired zero.
- RegBits, $clog2(RegisterCount): width of register numbers (regnum).
- Width, 32: operand width (word).

Ports:
- clk  in  1  rising-edge clock
- res  in  1  synchronous active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs1  in  RegBits  first source register
- in_rs2  in  RegBits  second source register
- in_rd  in  RegBits  destination register
- in_rd_write  in  1  instruction writes in_rd
- rf_q0_reg  out  RegBits  register set read address 0
- rf_q1_reg  out  RegBits  register set read address 1
- rf_q0  in  Width  register set read data 0
- rf_q1  in  Width  register set read data 1
- wb_valid  in  1  writeback commits this cycle (same signal as the register set write_enable)
- wb_reg  in  RegBits  writeback register
- wb_data  in  Width  writeback data
- out_valid  out  1  operands valid for execute
- out_ready  in  1  execute accepts
- out_op1  out  Width  rs1 value
- out_op2  out  Width  rs2 value
- out_rd  out  RegBits  destination register
- out_rd_write  out  1  destination write flag
- busy  out  RegisterCount  scoreboard; bit 0 is always 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on res, and has priority over all other events.
- Read addresses: rf_q0_reg = in_rs1 and rf_q1_reg = in_rs2, combinational at all times.
- Operand select (per source rs):
  - rs == 0 → 0.
  - Otherwise, wb_valid && wb_reg == rs → wb_data (bypass).
  - Otherwise → rf_q.
- Pending clear: clr[r] = wb_valid && wb_reg == r && r != 0. Effective busy: eb = busy & ~clr.
- Hazard: eb[in_rs1] || eb[in_rs2] || (in_rd_write && eb[in_rd]). Register 0 never contributes.
- in_ready = !res && !hazard && (!out_valid || out_ready). in_ready is combinational and meaningful only while in_valid is high.
- Accept (in_valid && in_ready): next edge loads out_op1, out_op2, out_rd and out_rd_write, and sets out_valid = 1.
- Output hold: if out_valid && !out_ready, all out_* hold stable. If out_ready && !accept, out_valid goes to 0 and the data outputs hold their last values.
- Scoreboard update each edge: busy_next = eb, then bit in_rd is set on accept when in_rd_write && in_rd != 0.
  - Set wins over a same-cycle clear of the same register.
  - wb_valid to a non-busy register or to register 0 is harmless: the bypass still applies and the scoreboard is unchanged.
- Latency: one cycle from accept to out_valid. Back-to-back accepts run at full throughput when there is no hazard and out_ready is held high.
- Reset:
  - busy = 0, out_valid = 0, out_op1 = 0, out_op2 = 0, out_rd = 0, out_rd_write = 0.
  - in_ready = 0 while res is high.
  - An in-flight output is dropped.
  - wb_* inputs in the reset cycle are ignored.

Test Plan:
1. Reset: assert res for 2 cycles with in_valid = 1 → in_ready = 0 during reset. After release: out_valid = 0, busy = 0, in_ready = 1.
2. Basic issue: register set x5 = 0x00001234, x6 = 0x00000010; issue rs1 = 5, rs2 = 6, rd = 7, rd_write = 1 → next cycle out_valid = 1, out_op1 = 0x1234, out_op2 = 0x10, out_rd = 7, busy[7] = 1.
3. RAW stall plus bypass: issue rs1 = 7 while busy[7] = 1 → in_ready = 0. In the cycle with wb_valid = 1, wb_reg = 7, wb_data = 0xCAFEBABE → in_ready = 1, captured out_op1 = 0xCAFEBABE, busy[7] = 0 afterwards.
4. Register 0: rs1 = 0, rs2 = 0, rd = 0, rd_write = 1 with rf_q0 = 0xFFFFFFFF → out_op1 = 0 and busy stays 0. wb_valid to register 0 causes no change.
5. Backpressure: out_ready = 0 for 3 cycles after an accept → out_* stable and in_ready = 0. With out_ready = 1 and a new in_valid → the next instruction is captured in that same cycle.
6. Simultaneous set and clear: busy[9] = 1, wb_valid to reg 9 in the same cycle as accepting an instruction with rd = 9, rd_write = 1 → busy[9] = 1 after the edge.
